uart_loop_controller: RTL and testbench

- Byte-loopback controller between a UART receiver and a UART transmitter.
- Captures each byte the receiver reports (RX_STATUS rising edge) into a small FIFO.
- Hands queued bytes to the transmitter one at a time with a one-cycle TX_EN strobe, only when the transmitter reports idle (TX_STATUS=1).
- Sits at top level between the uart_rx and uart_tx blocks.

---
 rtl/uart_loop_controller_pkg.sv | 14 +
 rtl/uart_loop_controller_byte_fifo.sv | 78 +++++++
 rtl/uart_loop_controller.sv | 109 ++++++++++
 tb/tb_uart_loop_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_loop_controller_pkg.sv
// Shared definitions for the UART byte-loopback controller: default byte width
// and the transmit-side state encoding.
package uart_loop_controller_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_loop_controller_byte_fifo.sv
// Synchronous circular-buffer FIFO; a pop in the same cycle as a push to a
// full FIFO frees the slot so the push is accepted.
module byte_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    import uart_loop_controller_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              wr_en_s, rd_en_s;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_en_s  = push && (!full || pop);
        rd_en_s  = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, cleared on reset so no stale byte survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_loop_controller.sv
// Byte loopback between a UART receiver and transmitter: captures each RX byte
// into a FIFO and hands them to the transmitter one strobe at a time.
module uart_loop_controller
    import uart_loop_controller_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_STATUS,
    input  logic              TX_STATUS,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_EN
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // The timeout spans strobe-to-strobe, so the IDLE pop and SEND cycles are
    // deducted from the time spent in WAIT_BUSY.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 3);

    tx_state_e         state_q, state_d;
    logic              rx_q;
    logic              tx_en_q, tx_en_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rise_s, pop_s, full_s, empty_s;
    logic [DATA_W-1:0] head_s;

    assign rise_s  = RX_STATUS & ~rx_q;
    assign TX_EN   = tx_en_q;
    assign TX_DATA = tx_data_q;

    byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (rise_s),
        .din   (RX_DATA),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Transmit handshake: next state, pop request and registered outputs.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = 1'b0;
        wait_cnt_d = wait_cnt_q;
        pop_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && TX_STATUS) begin
                    pop_s     = 1'b1;
                    tx_data_d = head_s;
                    state_d   = ST_SEND;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SEND: begin
                tx_en_d    = 1'b1;
                wait_cnt_d = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!TX_STATUS) begin
                    state_d = ST_WAIT_IDLE;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (TX_STATUS) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rx_q       <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_q       <= RX_STATUS;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_loop_controller.sv
// Scoreboard bench for uart_loop_controller: a queue-based reference model of
// accepted bytes, a monitor that checks every TX_EN strobe against it.
module tb_uart_loop_controller;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          sysclk = 1'b0;
    logic          reset;
    logic [DW-1:0] RX_DATA;
    logic          RX_STATUS;
    logic          TX_STATUS;
    logic [DW-1:0] TX_DATA;
    logic          TX_EN;

    logic tx_auto, tx_manual, tx_model;
    assign TX_STATUS = tx_auto ? tx_model : tx_manual;

    uart_loop_controller #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .RX_DATA   (RX_DATA),
        .RX_STATUS (RX_STATUS),
        .TX_STATUS (TX_STATUS),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_count = 0;
    int tx_last_cyc = 0;
    int rx_cyc = 0;
    logic prev_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    always @(posedge sysclk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the reference queue.
    always @(negedge sysclk) begin
        if (!reset) begin
            check("tx_en_during_reset", int'(TX_EN), 0);
        end else if (TX_EN) begin
            tx_count++;
            tx_last_cyc = cyc;
            check("tx_en_back_to_back", int'(prev_en), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_tx_en: got strobe with TX_DATA=0x%0h, required no strobe", TX_DATA);
            end else begin
                check("tx_data", int'(TX_DATA), int'(exp_q.pop_front()));
            end
        end
        prev_en = TX_EN;
    end

    // Transmitter stand-in: goes busy for a few cycles after most strobes,
    // occasionally ignores one so the timeout path is exercised.
    initial begin
        tx_model = 1'b1;
        forever begin
            @(negedge sysclk);
            if (TX_EN && tx_auto && reset && $urandom_range(3, 0) != 0) begin
                tx_model = 1'b0;
                repeat ($urandom_range(4, 1)) @(negedge sysclk);
                tx_model = 1'b1;
            end
        end
    end

    // Reference rule: a byte is kept only if fewer than DEPTH are outstanding.
    task automatic push_byte(input logic [DW-1:0] b, input int hold);
        @(negedge sysclk);
        RX_DATA   = b;
        RX_STATUS = 1'b1;
        rx_cyc    = cyc;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        repeat (hold) @(negedge sysclk);
        RX_STATUS = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (tx_count < target && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check(name, (tx_count >= target) ? 1 : 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        int base, t1, nb;
        reset = 1'b0; RX_STATUS = 1'b0; RX_DATA = '0;
        tx_auto = 1'b0; tx_manual = 1'b1;
        idle(3);
        check("reset_tx_en", int'(TX_EN), 0);
        check("reset_tx_data", int'(TX_DATA), 0);
        reset = 1'b1;
        idle(2);

        // Single byte with idle transmitter: strobe three cycles after the rise.
        push_byte(8'd35, 1);
        wait_tx(1, 20, "single_timeout");
        check("single_latency", tx_last_cyc - rx_cyc, 3);
        tx_manual = 1'b0; idle(2); tx_manual = 1'b1;
        idle(10);
        check("single_no_extra", tx_count, 1);

        // Busy transmitter holds bytes until it reports idle.
        tx_manual = 1'b0;
        push_byte(8'd35, 1);
        push_byte(8'd36, 1);
        idle(6);
        check("busy_no_tx", tx_count, 1);
        tx_manual = 1'b1;
        wait_tx(2, 20, "busy_first_timeout");
        tx_manual = 1'b0; idle(2);
        check("busy_second_waits", tx_count, 2);
        tx_manual = 1'b1;
        wait_tx(3, 20, "busy_second_timeout");
        idle(30);

        // Held RX_STATUS yields one byte.
        base = tx_count;
        push_byte(8'h5A, 5);
        idle(40);
        check("held_one_tx", tx_count - base, 1);

        // Overflow: only the first DEPTH bytes survive.
        base = tx_count;
        tx_manual = 1'b0;
        for (int i = 1; i <= 6; i++) push_byte(DW'(i), 1);
        check("overflow_model_depth", exp_q.size(), DEPTH);
        tx_auto = 1'b1;
        wait_tx(base + DEPTH, 200, "overflow_drain_timeout");
        idle(60);
        check("overflow_tx_count", tx_count - base, DEPTH);

        // Timeout: transmitter never goes busy.
        tx_auto = 1'b0; tx_manual = 1'b1;
        base = tx_count;
        push_byte(8'hA1, 1);
        push_byte(8'hA2, 1);
        wait_tx(base + 1, 20, "timeout_first");
        t1 = tx_last_cyc;
        wait_tx(base + 2, 40, "timeout_second");
        check("timeout_spacing", tx_last_cyc - t1, TMO);
        idle(30);

        // Randomized traffic against the reference queue.
        tx_auto = 1'b1;
        for (int r = 0; r < 20; r++) begin
            nb = $urandom_range(DEPTH, 1);
            for (int j = 0; j < nb; j++) begin
                push_byte(DW'($urandom_range(255, 0)), $urandom_range(3, 1));
                if ($urandom_range(1, 0) == 1) idle($urandom_range(3, 1));
            end
            for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge sysclk);
            check("random_drain", exp_q.size(), 0);
        end
        idle(40);

        // Asynchronous reset while bytes are queued.
        push_byte(8'hC3, 1);
        wait_tx(tx_count + 1, 40, "pre_reset_tx");
        idle(40);
        check("tx_data_holds", int'(TX_DATA), 8'hC3);
        tx_auto = 1'b0; tx_manual = 1'b0;
        push_byte(8'h11, 1);
        push_byte(8'h22, 1);
        push_byte(8'h33, 1);
        @(posedge sysclk); #2;
        reset = 1'b0;
        #1;
        check("async_reset_tx_en", int'(TX_EN), 0);
        check("async_reset_tx_data", int'(TX_DATA), 0);
        exp_q.delete();
        idle(3);
        reset = 1'b1;
        tx_manual = 1'b1;
        base = tx_count;
        idle(30);
        check("post_reset_no_tx", tx_count - base, 0);
        push_byte(8'h7E, 2);
        wait_tx(base + 1, 20, "post_reset_tx");
        idle(30);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
